// File: rtl/regfile_arb_pkg.sv
// rtl/regfile_arb_pkg.sv - shared widths and FSM encodings for the register-file write arbiter
package regfile_arb_pkg;

  localparam int REGFILE_ADDR_W = 5;
  localparam int REGFILE_DATA_W = 32;
  localparam int REGFILE_DEPTH  = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT  = 2'd1,
    ARB_LOCKED = 2'd2
  } arbState_t;

  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// rtl/regfile_wr_arbiter_rr_pick.sv - combinational round-robin picker, search starts at rrPtr
module rr_pick
  import regfile_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = ptrWidth(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] rrPtr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] winner
);

  localparam int IW = PTR_W + 1;

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt    = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      // one extra bit lets the rotated index wrap without a modulo operator
      idx = {1'b0, rrPtr} + IW'(k);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!found && req[idx[PTR_W-1:0]]) begin
        found                 = 1'b1;
        gnt[idx[PTR_W-1:0]]   = 1'b1;
        winner                = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter for the register-file write port
// Optional ownership locking is built when REGFILE_ARB_LOCK_EN is defined.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = REGFILE_ADDR_W,
  parameter int DATA_W = REGFILE_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] reqAddr,
  input  logic [NREQ*DATA_W-1:0] reqData,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [NREQ-1:0]        reqLock,
`endif
  output logic [NREQ-1:0]        gnt,
  output logic [ADDR_W-1:0]      wrAddr,
  output logic [DATA_W-1:0]      wrData,
  output logic                   write
);

  localparam int PTR_W = ptrWidth(NREQ);

  logic [PTR_W-1:0]  rrPtr;
  logic [PTR_W-1:0]  pickIdx;
  logic [PTR_W-1:0]  winIdx;
  logic [PTR_W-1:0]  nextPtr;
  logic [NREQ-1:0]   pickGnt;
  logic              transfer;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  arbState_t         state;
  arbState_t         nextState;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) uPick (
    .req    (req),
    .rrPtr  (rrPtr),
    .gnt    (pickGnt),
    .winner (pickIdx)
  );

`ifdef REGFILE_ARB_LOCK_EN
  logic [PTR_W-1:0] lockOwner;
  logic             ownerReq;
  logic             ownerLock;

  assign ownerReq  = req[lockOwner];
  assign ownerLock = reqLock[lockOwner];

  // while locked only the owner may be granted; the rotating search is bypassed
  always_comb begin
    gnt    = '0;
    winIdx = pickIdx;
    if (reset) begin
      gnt = '0;
    end else if (state == ARB_LOCKED) begin
      gnt[lockOwner] = ownerReq;
      winIdx         = lockOwner;
    end else begin
      gnt = pickGnt;
    end
  end
`else
  assign gnt    = reset ? '0 : pickGnt;
  assign winIdx = pickIdx;
`endif

  assign transfer = |(req & gnt);
  assign nextPtr  = (winIdx == PTR_W'(NREQ - 1)) ? '0 : winIdx + 1'b1;

  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        selAddr = reqAddr[i*ADDR_W +: ADDR_W];
        selData = reqData[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      ARB_IDLE:  if (|req) nextState = ARB_GRANT;
      ARB_GRANT: if (!(|req)) nextState = ARB_IDLE;
      default:   nextState = ARB_IDLE;
    endcase
`ifdef REGFILE_ARB_LOCK_EN
    if (state != ARB_LOCKED) begin
      if (transfer && reqLock[winIdx]) nextState = ARB_LOCKED;
    end else if ((transfer || !ownerReq) && !ownerLock) begin
      nextState = (|req) ? ARB_GRANT : ARB_IDLE;
    end else begin
      nextState = ARB_LOCKED;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write  <= 1'b0;
      wrAddr <= '0;
      wrData <= '0;
      rrPtr  <= '0;
      state  <= ARB_IDLE;
`ifdef REGFILE_ARB_LOCK_EN
      lockOwner <= '0;
`endif
    end else begin
      state <= nextState;
      write <= transfer;
      if (transfer) begin
        wrAddr <= selAddr;
        wrData <= selData;
      end
`ifdef REGFILE_ARB_LOCK_EN
      // pointer stays frozen for locked beats and moves past the owner on release
      if (transfer && (state != ARB_LOCKED || !ownerLock)) rrPtr <= nextPtr;
      if (transfer && state != ARB_LOCKED && reqLock[winIdx]) lockOwner <= winIdx;
`else
      if (transfer) rrPtr <= nextPtr;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - table-driven bench for regfile_wr_arbiter (REGFILE_ARB_LOCK_EN optional)
module tb_regfile_wr_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] reqAddr;
  logic [NREQ*DW-1:0] reqData;
`ifdef REGFILE_ARB_LOCK_EN
  logic [NREQ-1:0]   reqLock;
`endif
  logic [NREQ-1:0]   gnt;
  logic [AW-1:0]     wrAddr;
  logic [DW-1:0]     wrData;
  logic              write;

  logic [DW-1:0]     regs [32];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  expGnt;
    logic        expWrite;
    logic [4:0]  expAddr;
    logic [31:0] expData;
  } vec_t;

  vec_t vq[$];

  regfile_wr_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .reqAddr (reqAddr),
    .reqData (reqData),
`ifdef REGFILE_ARB_LOCK_EN
    .reqLock (reqLock),
`endif
    .gnt     (gnt),
    .wrAddr  (wrAddr),
    .wrData  (wrData),
    .write   (write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (write) regs[wrAddr] <= wrData;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic chkOut(input string tag, input logic [3:0] g, input logic w,
                        input logic [4:0] a, input logic [31:0] d);
    chk({tag, " gnt"}, 32'(gnt), 32'(g));
    chk({tag, " write"}, 32'(write), 32'(w));
    chk({tag, " wrAddr"}, 32'(wrAddr), 32'(a));
    chk({tag, " wrData"}, wrData, d);
  endtask

  initial begin
    reset   = 1'b1;
    req     = 4'b1111;
`ifdef REGFILE_ARB_LOCK_EN
    reqLock = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      reqAddr[i*AW +: AW] = (i == 2) ? 5'd1 : 5'(16 + i);
      reqData[i*DW +: DW] = (i == 2) ? 32'habcd_efab : 32'hC0DE_0000 + 32'(i);
    end

    // requester i writes addr 16+i / data C0DE000i, except requester 2 -> addr 1 / abcdefab
    vq.push_back('{4'b0000, 4'b0000, 1'b0, 5'd0,  32'h0});
    vq.push_back('{4'b0100, 4'b0100, 1'b0, 5'd0,  32'h0});
    vq.push_back('{4'b0000, 4'b0000, 1'b1, 5'd1,  32'habcd_efab});
    vq.push_back('{4'b0000, 4'b0000, 1'b0, 5'd1,  32'habcd_efab});
    vq.push_back('{4'b1000, 4'b1000, 1'b0, 5'd1,  32'habcd_efab});
    vq.push_back('{4'b1001, 4'b0001, 1'b1, 5'd19, 32'hC0DE_0003});
    vq.push_back('{4'b1001, 4'b1000, 1'b1, 5'd16, 32'hC0DE_0000});
    vq.push_back('{4'b0000, 4'b0000, 1'b1, 5'd19, 32'hC0DE_0003});
    vq.push_back('{4'b1111, 4'b0001, 1'b0, 5'd19, 32'hC0DE_0003});
    vq.push_back('{4'b1111, 4'b0010, 1'b1, 5'd16, 32'hC0DE_0000});
    vq.push_back('{4'b1111, 4'b0100, 1'b1, 5'd17, 32'hC0DE_0001});
    vq.push_back('{4'b1111, 4'b1000, 1'b1, 5'd1,  32'habcd_efab});
    vq.push_back('{4'b1111, 4'b0001, 1'b1, 5'd19, 32'hC0DE_0003});
    vq.push_back('{4'b1111, 4'b0010, 1'b1, 5'd16, 32'hC0DE_0000});
    vq.push_back('{4'b1111, 4'b0100, 1'b1, 5'd17, 32'hC0DE_0001});
    vq.push_back('{4'b1111, 4'b1000, 1'b1, 5'd1,  32'habcd_efab});
    vq.push_back('{4'b0000, 4'b0000, 1'b1, 5'd19, 32'hC0DE_0003});
    vq.push_back('{4'b0110, 4'b0010, 1'b0, 5'd19, 32'hC0DE_0003});
    vq.push_back('{4'b1000, 4'b1000, 1'b1, 5'd17, 32'hC0DE_0001});
    vq.push_back('{4'b0000, 4'b0000, 1'b1, 5'd19, 32'hC0DE_0003});

    // two reset cycles with every requester active
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chkOut($sformatf("reset%0d", c), 4'b0000, 1'b0, 5'd0, 32'h0);
    end
    reset = 1'b0;

    for (int r = 0; r < vq.size(); r++) begin
      req = vq[r].req;
      #1;
      chkOut($sformatf("vec%0d", r), vq[r].expGnt, vq[r].expWrite, vq[r].expAddr, vq[r].expData);
      @(negedge clk);
    end
    chk("regfile[1]", regs[1], 32'habcd_efab);
    chk("regfile[19]", regs[19], 32'hC0DE_0003);

    // reset raised in the cycle requester 1 holds the grant
    req = 4'b1111;
    #1 chk("midA gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    #1 chk("midB gnt pre", 32'(gnt), 32'h2);
    reset = 1'b1;
    #1 chkOut("midB", 4'b0000, 1'b1, 5'd16, 32'hC0DE_0000);
    @(negedge clk);
    reset = 1'b0;
    #1 chkOut("midC", 4'b0001, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    req = 4'b0000;
    #1 chkOut("midD", 4'b0000, 1'b1, 5'd16, 32'hC0DE_0000);
    @(negedge clk);

`ifdef REGFILE_ARB_LOCK_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    for (int b = 0; b < 4; b++) begin
      reqAddr[0 +: AW] = 5'(4 + b);
      reqLock = (b < 2) ? 4'b0001 : 4'b0000;
      #1;
      if (b < 3) chk($sformatf("lock%0d gnt", b), 32'(gnt), 32'h1);
      else       chk("lock3 gnt", 32'(gnt), 32'h2);
      if (b == 0) chk("lock0 write", 32'(write), 32'h0);
      else begin
        chk($sformatf("lock%0d write", b), 32'(write), 32'h1);
        chk($sformatf("lock%0d wrAddr", b), 32'(wrAddr), 32'(3 + b));
      end
      @(negedge clk);
    end
    req = 4'b0000;
    @(negedge clk);
    chk("regfile[6]", regs[6], 32'hC0DE_0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
